// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates branches/jumps, drives fetch redirects,
// and defers mispredict redirects until the delay slot has issued. Optional counters: BRANCH_STAT_EN.
package branch_pkg;
   typedef struct packed {
      logic        valid;
      logic        mispredict;
      logic        taken;
      logic [31:0] target;
      logic [31:0] pc;
   } branch_resolved_t;
endpackage

// state   | meaning
// S_IDLE  | no branch pending; accepts new branches
// S_WAIT  | mispredict latched, waiting for its delay slot to enter execute
module branch_resolver
   import branch_pkg::*;
#(
   parameter int OP_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  stall,
   input  logic                  br_valid,
   input  logic [OP_W-1:0]       br_op,
   input  logic [31:0]           br_pc,
   input  logic [25:0]           br_imm,
   input  logic [31:0]           rs_data,
   input  logic [31:0]           rt_data,
   input  logic                  pred_taken,
   input  logic [31:0]           pred_target,
   input  logic                  ds_valid,
   output branch_resolved_t      resolved_branch,
   output logic [31:0]           link_addr,
   output logic                  busy
`ifdef BRANCH_STAT_EN
   ,
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts
`endif
);

   localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_BNE    = OP_W'(1);
   localparam logic [OP_W-1:0] OP_BLEZ   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_BGTZ   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BLTZ   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BGEZ   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BLTZAL = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BGEZAL = OP_W'(7);
   localparam logic [OP_W-1:0] OP_J      = OP_W'(8);
   localparam logic [OP_W-1:0] OP_JAL    = OP_W'(9);
   localparam logic [OP_W-1:0] OP_JR     = OP_W'(10);
   localparam logic [OP_W-1:0] OP_JALR   = OP_W'(11);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state_q, state_d;
   branch_resolved_t res_q, res_d;
   branch_resolved_t pend_q, pend_d;
   logic [31:0]      link_q, link_d;
   logic [31:0]      pend_link_q, pend_link_d;

   logic             legal, taken, mispredict, accept;
   logic [31:0]      target, pc_plus4, br_tgt, j_tgt;
   branch_resolved_t cur;

   assign pc_plus4 = br_pc + 32'd4;
   assign br_tgt   = pc_plus4 + {{14{br_imm[15]}}, br_imm[15:0], 2'b00};
   assign j_tgt    = {pc_plus4[31:28], br_imm, 2'b00};

   always_comb begin
      legal  = 1'b1;
      taken  = 1'b0;
      target = br_tgt;
      case (br_op)
         OP_BEQ:               taken = (rs_data == rt_data);
         OP_BNE:               taken = (rs_data != rt_data);
         OP_BLEZ:              taken = ($signed(rs_data) <= 0);
         OP_BGTZ:              taken = ($signed(rs_data) > 0);
         OP_BLTZ, OP_BLTZAL:   taken = rs_data[31];
         OP_BGEZ, OP_BGEZAL:   taken = ~rs_data[31];
         OP_J, OP_JAL: begin
            taken  = 1'b1;
            target = j_tgt;
         end
         OP_JR, OP_JALR: begin
            taken  = 1'b1;
            target = rs_data;
         end
         default:              legal = 1'b0;
      endcase
   end

   // Target is compared only when taken; a not-taken branch is judged on direction alone.
   assign mispredict = (taken != pred_taken) | (taken & (target != pred_target));
   assign accept     = br_valid & ~stall & ~flush & (state_q == S_IDLE) & legal;

   always_comb begin
      cur            = '0;
      cur.valid      = 1'b1;
      cur.mispredict = mispredict;
      cur.taken      = taken;
      cur.target     = target;
      cur.pc         = br_pc;
   end

   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      res_d.valid = 1'b0;
      link_d      = link_q;
      pend_d      = pend_q;
      pend_link_d = pend_link_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!mispredict || ds_valid) begin
                  res_d  = cur;
                  link_d = br_pc + 32'd8;
               end else begin
                  pend_d      = cur;
                  pend_link_d = br_pc + 32'd8;
                  state_d     = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (ds_valid && !stall) begin
               res_d   = pend_q;
               link_d  = pend_link_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         res_q       <= '0;
         link_q      <= '0;
         pend_q      <= '0;
         pend_link_q <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         link_q      <= link_d;
         pend_q      <= pend_d;
         pend_link_q <= pend_link_d;
      end
   end

   assign resolved_branch = res_q;
   assign link_addr       = link_q;
   assign busy            = (state_q == S_WAIT);

`ifdef BRANCH_STAT_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else if (res_d.valid) begin
         stat_br_q <= stat_br_q + 32'd1;
         if (res_d.mispredict) stat_mp_q <= stat_mp_q + 32'd1;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`endif

endmodule
